// File: rtl/ifu_pkg.sv
// ifu_pkg: shared fetch-unit types and constants.
package ifu_pkg;
    typedef enum logic [1:0] {RESET_WAIT, RUN, DRAIN} ifu_state_e;
    localparam int IFU_FIFO_DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: 2-entry instruction FIFO with push/pop/flush and occupancy count.
module ifu_fifo import ifu_pkg::*; #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         empty
);
    logic [W-1:0] mem [IFU_FIFO_DEPTH];
    logic rd, wr, do_push, do_pop;
    assign empty = count == 2'd0;
    assign do_pop = pop && !empty;
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign do_push = push && (count != 2'(IFU_FIFO_DEPTH) || do_pop);
    assign dout = mem[rd];
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd <= 1'b0;
            wr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (do_push) mem[wr] <= din;
            rd <= rd ^ do_pop;
            wr <= wr ^ do_push;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit with credit-limited requests, redirect/drain and 2-entry FIFO.
// Define IFU_RSP_BYPASS_EN to forward a response straight to decode when the FIFO is empty.
module ifu import ifu_pkg::*; #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ifu_o_mem_req_valid,
    input  logic        ifu_i_mem_req_ready,
    output logic [31:0] ifu_o_mem_addr,
    input  logic        ifu_i_mem_rsp_valid,
    input  logic [31:0] ifu_i_mem_rsp_data,
    output logic        ifu_o_inst_valid,
    input  logic        ifu_i_inst_ready,
    output logic [31:0] ifu_o_inst,
    output logic [31:0] ifu_o_pc,
    input  logic        ifu_i_redirect_valid,
    input  logic [31:0] ifu_i_redirect_pc,
    output logic        ifu_o_misaligned
);
    ifu_state_e state, state_next;
    logic [31:0] pc;
    logic [31:0] pcq [2];
    logic [1:0] outstanding, kill_cnt, kill_next, out_next, fifo_count;
    logic [63:0] head;
    logic redir, issue, rsp_live, rsp_kill, byp, push, pop, fifo_empty, misaligned_q;

    assign ifu_o_mem_req_valid = state == RUN && (3'(outstanding) + 3'(fifo_count)) < 3'd2;
    assign ifu_o_mem_addr = pc;
    assign ifu_o_misaligned = misaligned_q;
    assign redir = ifu_i_redirect_valid && state != RESET_WAIT;
    assign issue = ifu_o_mem_req_valid && ifu_i_mem_req_ready;
    // while kill_cnt is nonzero every response belongs to a killed request
    assign rsp_live = ifu_i_mem_rsp_valid && kill_cnt == 2'd0;
    assign rsp_kill = ifu_i_mem_rsp_valid && kill_cnt != 2'd0;
`ifdef IFU_RSP_BYPASS_EN
    assign byp = rsp_live && fifo_empty && state == RUN;
`else
    assign byp = 1'b0;
`endif
    assign ifu_o_inst_valid = !fifo_empty || byp;
    assign ifu_o_inst = !fifo_empty ? head[31:0] : byp ? ifu_i_mem_rsp_data : NOP;
    assign ifu_o_pc = !fifo_empty ? head[63:32] : byp ? pcq[0] : 32'h0;
    assign push = rsp_live && !redir && !(byp && ifu_i_inst_ready);
    assign pop = !fifo_empty && ifu_i_inst_ready && !redir;

    ifu_fifo #(.W(64)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(redir),
        .din({pcq[0], ifu_i_mem_rsp_data}),
        .dout(head),
        .count(fifo_count),
        .empty(fifo_empty)
    );

    // a redirect turns everything still in flight (including this cycle's issue) into kills
    always_comb begin
        kill_next = redir ? 2'(outstanding + kill_cnt + 2'(issue) - 2'(ifu_i_mem_rsp_valid))
                          : kill_cnt - 2'(rsp_kill);
        out_next = redir ? 2'd0 : outstanding + 2'(issue) - 2'(rsp_live);
        state_next = state == RESET_WAIT ? RUN : kill_next != 2'd0 ? DRAIN : RUN;
    end

    always_ff @(posedge clk) begin
        state <= rst ? RESET_WAIT : state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_VECTOR;
            outstanding <= 2'd0;
            kill_cnt <= 2'd0;
            misaligned_q <= 1'b0;
        end else begin
            pc <= redir ? {ifu_i_redirect_pc[31:2], 2'b00} : issue ? pc + 32'd4 : pc;
            outstanding <= out_next;
            kill_cnt <= kill_next;
            misaligned_q <= redir && ifu_i_redirect_pc[1:0] != 2'b00;
        end
    end

    // in-order PC tags of live requests; the write slot accounts for a same-cycle return
    always_ff @(posedge clk) begin
        if (rsp_live) pcq[0] <= pcq[1];
        if (issue) pcq[1'(outstanding - 2'(rsp_live))] <= pc;
    end
endmodule
